// File: rtl/enemy_bullet_arb.sv
// Round-robin enemy fire arbiter that owns a shared pool of bullet slots and moves them downward.
// Define ENEMY_FIRE_COOLDOWN_EN to add a per-column cooldown counted in movement ticks.
module enemy_bullet_arb #(
  parameter int NUM_REQ      = 8,
  parameter int NUM_SLOTS    = 4,
  parameter int BULLET_SPEED = 3,
  parameter int STEP_DELAY   = 650000,
  parameter int FLOOR_Y      = 736
`ifdef ENEMY_FIRE_COOLDOWN_EN
  ,
  parameter int COOLDOWN_TICKS = 8
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       game_en,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0][11:0]   req_x,
  input  logic [NUM_REQ-1:0][11:0]   req_y,
  input  logic [NUM_SLOTS-1:0]       slot_hit,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_SLOTS-1:0]       slot_active,
  output logic [NUM_SLOTS-1:0][11:0] slot_x,
  output logic [NUM_SLOTS-1:0][11:0] slot_y,
  output logic [3:0]                 free_cnt
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CW = $clog2(STEP_DELAY);
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DELAY - 1);
  localparam logic [12:0]   FLOOR13  = 13'(FLOOR_Y);
  localparam logic [12:0]   SPEED13  = 13'(BULLET_SPEED);

  logic [CW-1:0]              tick_cnt_reg;
  logic                       tick_reg;
  logic [PW-1:0]              rr_ptr_reg;
  logic [NUM_REQ-1:0]         grant_reg;
  logic [NUM_SLOTS-1:0]       active_reg;
  logic [NUM_SLOTS-1:0][11:0] x_reg;
  logic [NUM_SLOTS-1:0][11:0] y_reg;
  logic [3:0]                 free_cnt_reg;

  logic [NUM_SLOTS-1:0]       act_next;
  logic [NUM_SLOTS-1:0][11:0] x_next;
  logic [NUM_SLOTS-1:0][11:0] y_next;
  logic [3:0]                 free_next;

  logic [NUM_REQ-1:0] eligible;
  logic               win_found;
  logic [PW-1:0]      win_idx;
  logic               free_found;
  logic [SW-1:0]      free_idx;
  logic               do_grant;
  logic               move;
  logic [NUM_REQ-1:0] grant_next;
  logic [PW-1:0]      rr_next;
  logic [12:0]        y_sum [NUM_SLOTS];

`ifdef ENEMY_FIRE_COOLDOWN_EN
  localparam int DW = $clog2(COOLDOWN_TICKS + 1);
  logic [DW-1:0] cool_reg [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cool
    // A fresh grant reloads the counter even if a tick lands on the same edge.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cool_reg[gi] <= '0;
      end else if (do_grant && (win_idx == PW'(gi))) begin
        cool_reg[gi] <= DW'(COOLDOWN_TICKS);
      end else if (move && (cool_reg[gi] != '0)) begin
        cool_reg[gi] <= cool_reg[gi] - DW'(1);
      end
    end
    assign eligible[gi] = req[gi] && (cool_reg[gi] == '0);
  end
`else
  assign eligible = req;
`endif

  // Two ascending passes give the first requester at or after rr_ptr with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int c = 0; c < NUM_REQ; c++) begin
      if (!win_found && eligible[c] && (PW'(c) >= rr_ptr_reg)) begin
        win_found = 1'b1;
        win_idx   = PW'(c);
      end
    end
    for (int c = 0; c < NUM_REQ; c++) begin
      if (!win_found && eligible[c] && (PW'(c) < rr_ptr_reg)) begin
        win_found = 1'b1;
        win_idx   = PW'(c);
      end
    end
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (!active_reg[k]) begin
        free_found = 1'b1;
        free_idx   = SW'(k);
      end
    end
  end

  assign do_grant   = game_en && win_found && free_found;
  assign move       = tick_reg && game_en;
  assign grant_next = NUM_REQ'(1) << win_idx;
  assign rr_next    = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);

  // 13-bit sum so a spawn near 4095 retires instead of wrapping to the top.
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_sum
    assign y_sum[gi] = {1'b0, y_reg[gi]} + SPEED13;
  end

  always_comb begin
    act_next = active_reg;
    x_next   = x_reg;
    y_next   = y_reg;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (active_reg[k]) begin
        if (slot_hit[k]) begin
          act_next[k] = 1'b0;
        end else if (move) begin
          if (y_sum[k] >= FLOOR13) begin
            act_next[k] = 1'b0;
          end else begin
            y_next[k] = y_sum[k][11:0];
          end
        end
      end else if (do_grant && (free_idx == SW'(k))) begin
        act_next[k] = 1'b1;
        x_next[k]   = req_x[win_idx];
        y_next[k]   = req_y[win_idx];
      end
    end
  end

  always_comb begin
    free_next = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      free_next = free_next + {3'b000, ~act_next[k]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt_reg <= '0;
      tick_reg     <= 1'b0;
      rr_ptr_reg   <= '0;
      grant_reg    <= '0;
      active_reg   <= '0;
      x_reg        <= '0;
      y_reg        <= '0;
      free_cnt_reg <= 4'(NUM_SLOTS);
    end else begin
      tick_reg <= 1'b0;
      if (game_en) begin
        if (tick_cnt_reg == CNT_LAST) begin
          tick_cnt_reg <= '0;
          tick_reg     <= 1'b1;
        end else begin
          tick_cnt_reg <= tick_cnt_reg + CW'(1);
        end
      end
      grant_reg <= do_grant ? grant_next : '0;
      if (do_grant) begin
        rr_ptr_reg <= rr_next;
      end
      active_reg   <= act_next;
      x_reg        <= x_next;
      y_reg        <= y_next;
      free_cnt_reg <= free_next;
    end
  end

  assign grant       = grant_reg;
  assign slot_active = active_reg;
  assign slot_x      = x_reg;
  assign slot_y      = y_reg;
  assign free_cnt    = free_cnt_reg;

endmodule
